mux_pipe_arb: RTL and testbench
===============================

Name: mux_pipe_arb

Overview:
- Parametrised successor to the datapath's 16-bit 2:1 combinational mux.
- Selects one of NUM_IN WIDTH-bit source channels, either by explicit select or by round-robin arbitration.
- Registers the chosen word into a single-entry output stage with valid/ready handshakes on both sides.
- Sits between register-file read ports / ALU result sources and downstream datapath consumers.

Parameters:
- WIDTH, 16, data width of each channel and of out_data.
- NUM_IN, 4, number of source channels (2..2**SEL_W).
- SEL_W, 2, width of sel and out_src; 2**SEL_W >= NUM_IN is required.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened channels; channel i = bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- sel  input  SEL_W  explicit channel select, used when rr_en=0.
- rr_en  input  1  1 = round-robin mode, 0 = explicit-select mode; sampled every cycle.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.
- sel_err  output  1  registered one-cycle pulse: explicit sel >= NUM_IN while that channel would be requested.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). Reset asserts immediately; deassertion is taken synchronously.
- Reset values:
  - out_data=0, out_src=0, out_valid=0, sel_err=0.
  - RR pointer = NUM_IN-1, so channel 0 has first priority.
  - In-flight word is discarded.
- load_en = !out_valid || out_ready (output empty, or being drained this cycle).
- Channel choice, explicit mode (rr_en=0):
  - cand = sel.
  - If sel >= NUM_IN: no candidate, all in_ready=0, no load. sel_err pulses high the next cycle when any in_valid is set and load_en=1.
- Channel choice, round-robin mode (rr_en=1):
  - cand = first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... modulo NUM_IN.
  - No in_valid set -> no candidate.
- Handshake:
  - in_ready[i] = load_en && (i == cand); all other bits 0.
  - in_ready never depends on in_valid of the same channel in explicit mode.
- Transfer:
  - Occurs when in_valid[cand] && in_ready[cand].
  - On the next edge: out_data <= channel cand, out_src <= cand, out_valid <= 1.
  - Latency: 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0; out_data and out_src hold their values.
- Simultaneous drain + transfer: output replaced in the same cycle; out_valid stays 1. Full throughput is one word per cycle.
- Stall: out_valid && !out_ready -> out_data and out_src hold, all in_ready=0.
- RR pointer:
  - Updates to cand only on a transfer with rr_en=1.
  - Held in explicit mode.
  - Mode switches never reset it.
- Wrap-around: with ptr = NUM_IN-1 the scan starts at channel 0.
- No combinational path from in_data to out_data.
- in_valid -> in_ready combinational path exists in RR mode only.

Test Plan:
- Reset mid-transfer:
  - Stimulus: out_valid=1, out_data=16'h1234, out_ready=0, then rst_n low for 3 ns between edges.
  - Response: out_valid=0 and out_data=0 immediately. First RR grant after release goes to channel 0.
- Explicit select, 2:1 equivalence:
  - Stimulus: NUM_IN=2, rr_en=0, in0=16'h0000, in1=16'hFFFE, out_ready=1, sel=0, then sel=1.
  - Response: out_data 16'h0000 (out_src 0), then 16'hFFFE (out_src 1), each one cycle after accept. in_ready[1-sel]=0 throughout.
- Back-pressure:
  - Stimulus: sel=2, in_valid[2]=1 with data 16'hA5A5, out_ready=0 for 4 cycles.
  - Response: out_data=16'hA5A5 and out_valid=1 hold. in_ready=4'b0000 after the first accept. When out_ready=1, the next word is loaded in the same cycle with no bubble.
- Round-robin fairness:
  - Stimulus: rr_en=1, in_valid=4'b1011 continuously, out_ready=1.
  - Response: out_src sequence 0,1,3,0,1,3. Channel 2 is never granted.
- Out-of-range select:
  - Stimulus: NUM_IN=3, SEL_W=2, rr_en=0, sel=3, in_valid=3'b111.
  - Response: in_ready=0, no load, sel_err=1 one cycle later. sel_err=0 once sel=1.
- Mode switch:
  - Stimulus: RR grants channel 1, switch to rr_en=0 for 3 transfers on sel=3, then back to rr_en=1 with all valid.
  - Response: the next RR grant is channel 2 (pointer held at 1 through explicit mode).

Source files
------------

// File: rtl/mux_pipe_arb.sv
// mux_pipe_arb
// ------------------------------------------------------------------------
// Parametrised N:1 channel selector with a registered single-entry output
// stage. A channel is chosen either by an explicit select (rr_en=0) or by a
// round-robin arbiter (rr_en=1). The chosen word is registered into the
// output stage with valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flattened source channels, channel i = [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   sel        explicit channel select, used when rr_en=0
//   rr_en      1 = round-robin, 0 = explicit select (sampled every cycle)
//   out_data   registered selected word
//   out_src    registered index of the channel that supplied out_data
//   out_valid  output stage holds a word
//   out_ready  consumer accepts out_data this cycle
//   sel_err    registered pulse: explicit sel out of range while requested
// ------------------------------------------------------------------------
module mux_pipe_arb #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    rr_en,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [SEL_W-1:0] rr_ptr;     // last channel granted in round-robin mode
    logic [SEL_W-1:0] cand;       // channel offered the output stage
    logic             cand_ok;    // cand is a real channel this cycle
    logic             load_en;    // output stage can take a word
    logic             xfer;       // a word moves into the output stage
    logic             sel_oor;    // explicit select points past the last channel
    logic             err_nxt;
    logic [WIDTH-1:0] cand_data;

    // ptr + k stays below 2*NUM_IN, so one conditional subtract replaces
    // a general modulo.
    function automatic logic [SEL_W-1:0] wrap_idx(input int s);
        if (s >= NUM_IN) return SEL_W'(s - NUM_IN);
        return SEL_W'(s);
    endfunction

    assign load_en = !out_valid || out_ready;
    assign sel_oor = int'(sel) >= NUM_IN;

    // Candidate selection.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cand    = '0;
        cand_ok = 1'b0;
        if (!rr_en) begin
            cand    = sel;
            cand_ok = !sel_oor;
        end else begin
            // Scan from the farthest position back to ptr+1; the last hit
            // written is the nearest valid channel after the pointer.
            for (int k = NUM_IN; k >= 1; k--) begin
                if (in_valid[wrap_idx(int'(rr_ptr) + k)]) begin
                    cand    = wrap_idx(int'(rr_ptr) + k);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    // Ready decode and data mux. Explicit mode never looks at in_valid here,
    // so in_ready only depends on in_valid when round-robin is active.
    always_comb begin
        in_ready  = '0;
        cand_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(cand) == i) begin
                in_ready[i] = load_en && cand_ok;
                cand_data   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer    = |(in_ready & in_valid);
    assign err_nxt = !rr_en && sel_oor && (|in_valid) && load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: out_data is a single datapath register, not a memory, so
            // it is cleared on reset to give consumers a defined value.
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            // Pointing at the last channel gives channel 0 first priority.
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            sel_err <= err_nxt;
            if (xfer) begin
                out_data  <= cand_data;
                out_src   <= cand;
                out_valid <= 1'b1;
                if (rr_en) rr_ptr <= cand;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_arb.sv
// Self-checking bench for mux_pipe_arb. Two instances share stimulus: a
// 4-channel one and a 3-channel one (so sel=3 is out of range there).
// Each cycle the in_ready vectors are checked before the edge and the
// registered outputs #1 after it, against a transaction-level model.
module tb_mux_pipe_arb;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid, a_ready;
    logic [1:0]     a_sel, a_src;
    logic           a_rr, a_oready, a_ovalid, a_err;
    logic [W-1:0]   a_out;

    logic [3*W-1:0] b_data;
    logic [2:0]     b_valid, b_ready;
    logic [1:0]     b_sel, b_src;
    logic           b_rr, b_oready, b_ovalid, b_err;
    logic [W-1:0]   b_out;

    mux_pipe_arb #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .sel(a_sel), .rr_en(a_rr), .out_data(a_out),
        .out_src(a_src), .out_valid(a_ovalid), .out_ready(a_oready),
        .sel_err(a_err));

    mux_pipe_arb #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .sel(b_sel), .rr_en(b_rr), .out_data(b_out),
        .out_src(b_src), .out_valid(b_ovalid), .out_ready(b_oready),
        .sel_err(b_err));

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] w [4];          // channel words driven this cycle
    logic [3:0]   obs_a_ready;    // in_ready seen before the last edge
    logic [2:0]   obs_b_ready;

    // Reference model state, index 0 = 4-channel, 1 = 3-channel.
    logic         m_v   [2];
    logic [W-1:0] m_d   [2];
    int           m_src [2];
    int           m_ptr [2];
    logic         m_err [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_d[k] = '0; m_src[k] = 0; m_err[k] = 1'b0;
        end
        m_ptr[0] = 3;
        m_ptr[1] = 2;
    endtask

    // One cycle of the output stage as a transaction: who is offered,
    // whether a word moves, and what the stage holds afterwards.
    task automatic model_step(input int k, input int n, input logic [3:0] valid,
                              input int sel, input logic rr, input logic ordy,
                              output logic [3:0] exp_ready);
        int c;
        logic load;
        logic [3:0] live;
        live = valid & 4'((1 << n) - 1);
        load = !m_v[k] || ordy;
        c = -1;
        if (!rr) begin
            if (sel < n) c = sel;
        end else begin
            for (int j = 1; j <= n; j++)
                if (c < 0 && live[(m_ptr[k] + j) % n]) c = (m_ptr[k] + j) % n;
        end
        exp_ready = (load && c >= 0) ? 4'(1 << c) : 4'b0;
        m_err[k] = !rr && sel >= n && live != 0 && load;
        if (load && c >= 0 && live[c]) begin
            m_v[k] = 1'b1; m_d[k] = w[c]; m_src[k] = c;
            if (rr) m_ptr[k] = c;
        end else if (ordy) begin
            m_v[k] = 1'b0;
        end
    endtask

    task automatic check_outs();
        check("a_out_valid", a_ovalid, m_v[0]);
        check("a_out_data",  a_out,    m_d[0]);
        check("a_out_src",   a_src,    m_src[0]);
        check("a_sel_err",   a_err,    m_err[0]);
        check("b_out_valid", b_ovalid, m_v[1]);
        check("b_out_data",  b_out,    m_d[1]);
        check("b_out_src",   b_src,    m_src[1]);
        check("b_sel_err",   b_err,    m_err[1]);
    endtask

    // Drive one cycle on both instances, check ready, clock, check outputs.
    task automatic apply(input logic [3:0] valid, input logic [1:0] sel,
                         input logic rr, input logic ordy);
        logic [3:0] ea, eb;
        a_valid = valid;      b_valid = valid[2:0];
        a_sel = sel;          b_sel = sel;
        a_rr = rr;            b_rr = rr;
        a_oready = ordy;      b_oready = ordy;
        for (int i = 0; i < 4; i++) a_data[i*W +: W] = w[i];
        for (int i = 0; i < 3; i++) b_data[i*W +: W] = w[i];
        #1;
        obs_a_ready = a_ready;
        obs_b_ready = b_ready;
        model_step(0, 4, valid, int'(sel), rr, ordy, ea);
        model_step(1, 3, valid, int'(sel), rr, ordy, eb);
        check("a_in_ready", a_ready, ea);
        check("b_in_ready", b_ready, eb[2:0]);
        @(posedge clk);
        #1;
        check_outs();
    endtask

    int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) w[i] = '0;
        a_data = '0; a_valid = '0; a_sel = '0; a_rr = 1'b0; a_oready = 1'b0;
        b_data = '0; b_valid = '0; b_sel = '0; b_rr = 1'b0; b_oready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", a_ovalid, 0);
        check("reset_out_data",  a_out,    0);
        check("reset_out_src",   a_src,    0);
        check("reset_sel_err",   a_err,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a stalled transfer.
        w[0] = 16'h1234;
        apply(4'b0001, 2'd0, 1'b0, 1'b0);
        check("held_word", a_out, 16'h1234);
        apply(4'b0001, 2'd0, 1'b0, 1'b0);
        check("stall_ready", obs_a_ready, 4'b0000);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", a_ovalid, 0);
        check("async_rst_data",  a_out,    0);
        #2 rst_n = 1'b1;
        model_reset();

        // Round-robin fairness straight out of reset: channel 0 first.
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
        for (int i = 0; i < 6; i++) begin
            apply(4'b1011, 2'd0, 1'b1, 1'b1);
            check("rr_fair_src", a_src, rr_seq[i]);
            check("rr_no_ch2", obs_a_ready[2], 0);
        end

        // Explicit select, 2:1 behaviour including extreme data.
        w[0] = 16'h0000; w[1] = 16'hFFFE;
        apply(4'b0011, 2'd0, 1'b0, 1'b1);
        check("mux_sel0_data",  a_out, 16'h0000);
        check("mux_sel0_src",   a_src, 0);
        check("mux_sel0_ready", obs_a_ready, 4'b0001);
        apply(4'b0011, 2'd1, 1'b0, 1'b1);
        check("mux_sel1_data",  a_out, 16'hFFFE);
        check("mux_sel1_src",   a_src, 1);
        check("mux_sel1_ready", obs_a_ready, 4'b0010);

        // Back-pressure, then release with no bubble.
        w[2] = 16'hA5A5;
        apply(4'b0100, 2'd2, 1'b0, 1'b1);
        check("bp_first", a_out, 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            apply(4'b0100, 2'd2, 1'b0, 1'b0);
            check("bp_hold_data",  a_out, 16'hA5A5);
            check("bp_hold_valid", a_ovalid, 1);
            check("bp_ready_low",  obs_a_ready, 4'b0000);
        end
        w[2] = 16'h5A5A;
        apply(4'b0100, 2'd2, 1'b0, 1'b1);
        check("bp_release_ready", obs_a_ready, 4'b0100);
        check("bp_release_data",  a_out, 16'h5A5A);
        check("bp_release_valid", a_ovalid, 1);

        // Out-of-range select on the 3-channel instance.
        apply(4'b0111, 2'd3, 1'b0, 1'b1);
        check("oor_ready", obs_b_ready, 3'b000);
        check("oor_err",   b_err, 1);
        check("oor_noload", b_ovalid, 0);
        apply(4'b0111, 2'd1, 1'b0, 1'b1);
        check("oor_err_clear", b_err, 0);
        check("oor_src1", b_src, 1);

        // Mode switch: pointer survives explicit-mode transfers.
        apply(4'b0010, 2'd0, 1'b1, 1'b1);
        check("ms_grant1", a_src, 1);
        w[3] = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            apply(4'b1000, 2'd3, 1'b0, 1'b1);
            check("ms_explicit3", a_src, 3);
        end
        apply(4'b1111, 2'd0, 1'b1, 1'b1);
        check("ms_next_rr", a_src, 2);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) w[i] = W'($urandom);
            apply(4'($urandom), 2'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
